rtc_bus_arbiter: RTL and testbench

- Owns the multiplexed address/data bus to the external RTC: the CSO, ADO, WRO and RDO strobes and Bus_Dato_Dir.
- Arbitrates between two requesters: port 0 is the user/config write path (Top_Instanciacion side); port 1 is the periodic refresh/PicoBlaze read path.
- Sequences each granted request as an address phase followed by a data phase, with programmable strobe and gap widths.
- Sits between the request sources and the top-level inout pad; the top assigns Bus_Dato_Dir = bus_oe ? bus_out : 8'hZZ.

---
 rtl/rtc_bus_pkg.sv | 24 ++
 rtl/rtc_rr_arb2.sv | 33 +++
 rtl/rtc_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter: FSM states, requester
// indices, default phase timing and the BCD helper used by RTC_BCD_CHECK_EN.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_STB = 3'd1,
    ST_A_GAP = 3'd2,
    ST_D_STB = 3'd3,
    ST_D_GAP = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int REQ_CFG = 0;
  localparam int REQ_REF = 1;

  localparam int unsigned T_PHASE_DEF = 10;
  localparam int unsigned T_GAP_DEF   = 4;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// index opposite the last grant. last_grant starts at REQ_REF so config wins first.
module rtc_rr_arb2
  import rtc_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       idx
);

  logic last_grant;

  always_comb begin
    valid = |req;
    if (&req)
      idx = ~last_grant;
    else if (req[REQ_REF])
      idx = 1'(REQ_REF);
    else
      idx = 1'(REQ_CFG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= 1'(REQ_REF);
    else if (take)
      last_grant <= idx;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Owns the multiplexed RTC bus: arbitrates two requesters and runs each grant as
// address phase + data phase. Optional BCD write-data rejection: RTC_BCD_CHECK_EN.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE = T_PHASE_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [1:0] err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [2:0] dbg_state
);

  localparam logic [7:0] PH_LD  = 8'(T_PHASE - 1);
  localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       gnt_valid, gnt_idx, take;
  logic [7:0] gnt_addr, gnt_wdata;
  logic       idx_l, we_l;
  logic [7:0] addr_l, wdata_l;
  logic       nxt_idx, nxt_we;
  logic [7:0] nxt_addr, nxt_wdata;
  logic       o_cs_n, o_ad_n, o_wr_n, o_rd_n, o_oe;
  logic [7:0] o_out;
  logic [1:0] ack_d;
`ifdef RTC_BCD_CHECK_EN
  logic [1:0] err_d;
`endif

  rtc_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (take),
    .valid (gnt_valid),
    .idx   (gnt_idx)
  );

  assign gnt_addr  = gnt_idx ? addr1  : addr0;
  assign gnt_wdata = gnt_idx ? wdata1 : wdata0;

  // Outputs are registered from the next state, so the grant cycle must see
  // the incoming request's fields before they are latched.
  assign nxt_idx   = take ? gnt_idx     : idx_l;
  assign nxt_we    = take ? we[gnt_idx] : we_l;
  assign nxt_addr  = take ? gnt_addr    : addr_l;
  assign nxt_wdata = take ? gnt_wdata   : wdata_l;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    err_d   = 2'b00;
`endif
    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          take = 1'b1;
`ifdef RTC_BCD_CHECK_EN
          if (we[gnt_idx] && !is_bcd(gnt_wdata)) begin
            err_d[gnt_idx] = 1'b1;
          end else begin
            state_d = ST_A_STB;
            cnt_d   = PH_LD;
          end
`else
          state_d = ST_A_STB;
          cnt_d   = PH_LD;
`endif
        end
      end
      ST_A_STB: begin
        if (cnt == 8'd0) begin
          state_d = ST_A_GAP;
          cnt_d   = GAP_LD;
        end else cnt_d = cnt - 8'd1;
      end
      ST_A_GAP: begin
        if (cnt == 8'd0) begin
          state_d = ST_D_STB;
          cnt_d   = PH_LD;
        end else cnt_d = cnt - 8'd1;
      end
      ST_D_STB: begin
        if (cnt == 8'd0) begin
          state_d = ST_D_GAP;
          cnt_d   = GAP_LD;
        end else cnt_d = cnt - 8'd1;
      end
      ST_D_GAP: begin
        if (cnt == 8'd0) begin
          state_d = ST_DONE;
          cnt_d   = 8'd0;
        end else cnt_d = cnt - 8'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad/strobe values for the cycle the FSM is about to enter.
  always_comb begin
    o_cs_n = 1'b1;
    o_ad_n = 1'b1;
    o_wr_n = 1'b1;
    o_rd_n = 1'b1;
    o_oe   = 1'b0;
    o_out  = bus_out;
    ack_d  = 2'b00;
    case (state_d)
      ST_A_STB: begin
        o_cs_n = 1'b0;
        o_ad_n = 1'b0;
        o_wr_n = 1'b0;
        o_oe   = 1'b1;
        o_out  = nxt_addr;
      end
      ST_A_GAP: o_oe = (cnt_d == GAP_LD);
      ST_D_STB: begin
        o_cs_n = 1'b0;
        if (nxt_we) begin
          o_wr_n = 1'b0;
          o_oe   = 1'b1;
          o_out  = nxt_wdata;
        end else o_rd_n = 1'b0;
      end
      ST_D_GAP: o_oe = nxt_we && (cnt_d == GAP_LD);
      ST_DONE:  ack_d[nxt_idx] = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      idx_l   <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= 8'd0;
      wdata_l <= 8'd0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'd0;
      ack     <= 2'b00;
      rdata   <= 8'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      if (take) begin
        idx_l   <= gnt_idx;
        we_l    <= we[gnt_idx];
        addr_l  <= gnt_addr;
        wdata_l <= gnt_wdata;
      end
      cs_n    <= o_cs_n;
      ad_n    <= o_ad_n;
      wr_n    <= o_wr_n;
      rd_n    <= o_rd_n;
      bus_oe  <= o_oe;
      bus_out <= o_out;
      ack     <= ack_d;
      if (state == ST_D_STB && cnt == 8'd0 && !we_l)
        rdata <= bus_in;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 2'b00;
    else        err <= err_d;
  end
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: RTC device model on the pins, transaction-level
// reference (arbitration order, latency, register contents) and ack-driven scoreboard.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  localparam int TP  = int'(T_PHASE_DEF);
  localparam int TG  = int'(T_GAP_DEF);
  localparam int LAT = 1 + 2 * (TP + TG);

  typedef struct packed {
    logic        idx;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00, we = 2'b00;
  logic [7:0] addr0 = 8'd0, addr1 = 8'd0, wdata0 = 8'd0, wdata1 = 8'd0;
  logic [1:0] ack, err;
  logic [7:0] rdata, bus_out, bus_in;
  logic       busy, bus_oe, cs_n, ad_n, wr_n, rd_n;
  logic [2:0] dbg_state;

  int   checks = 0, failures = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t pq[2][$];
  logic [7:0] ref_mem [256];
  logic [7:0] init_mem [256];
  logic [7:0] dev_mem [256];
  logic [7:0] dev_addr = 8'd0;
  logic       dev_loaded = 1'b0;
  logic       lg_model = 1'b1;
  logic [7:0] last_rd = 8'd0;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC device: latches the address phase, stores write data, returns register contents
  always @(negedge clk) begin
    if (!dev_loaded) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_mem[i];
      dev_loaded <= 1'b1;
    end else if (!cs_n && !ad_n) dev_addr <= bus_out;
    else if (!cs_n && !wr_n && bus_oe) dev_mem[dev_addr] <= bus_out;
  end
  assign bus_in = dev_mem[dev_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin monitor: measures each transaction's phases, scored when ack appears
  int a_cnt = 0, a_bad = 0, gap_cnt = 0, gap_oe = 0, d_cnt = 0, wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
  logic [7:0] seen_addr = 8'd0, seen_wd = 8'd0;

  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_ack", 32'(ack), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ack_onehot", 32'(ack), e.idx ? 32'd2 : 32'd1);
    check("ack_cycle", cyc, e.cyc);
    check("addr_phase_len", a_cnt, TP);
    check("addr_phase_strobes", a_bad, 0);
    check("addr_value", 32'(seen_addr), 32'(e.addr));
    check("gap_len", gap_cnt, TG);
    check("addr_hold", gap_oe, 1);
    check("data_phase_len", d_cnt, TP);
    check("err_quiet", 32'(err), 32'd0);
    if (e.we) begin
      check("wr_strobe_len", wr_cnt, TP);
      check("wr_no_rd", rd_cnt, 0);
      check("wr_oe_len", oe_cnt, TP);
      check("wr_data", 32'(seen_wd), 32'(e.data));
      check("rdata_held", 32'(rdata), 32'(last_rd));
    end else begin
      check("rd_strobe_len", rd_cnt, TP);
      check("rd_no_wr", wr_cnt, 0);
      check("rd_oe_off", oe_cnt, 0);
      check("rdata", 32'(rdata), 32'(e.data));
      last_rd = e.data;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      a_cnt <= 0; a_bad <= 0; gap_cnt <= 0; gap_oe <= 0;
      d_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; oe_cnt <= 0;
    end else begin
      if (!cs_n && !ad_n) begin
        a_cnt <= a_cnt + 1;
        if (a_cnt == 0) seen_addr <= bus_out;
        if (!bus_oe || wr_n || !rd_n) a_bad <= a_bad + 1;
      end else if (!cs_n) begin
        d_cnt <= d_cnt + 1;
        if (!wr_n) begin
          wr_cnt  <= wr_cnt + 1;
          seen_wd <= bus_out;
        end
        if (!rd_n) rd_cnt <= rd_cnt + 1;
        if (bus_oe) oe_cnt <= oe_cnt + 1;
      end else if (a_cnt != 0 && d_cnt == 0) begin
        gap_cnt <= gap_cnt + 1;
        if (bus_oe) gap_oe <= gap_oe + 1;
      end
      if (ack != 2'b00) begin
        score();
        a_cnt <= 0; a_bad <= 0; gap_cnt <= 0; gap_oe <= 0;
        d_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; oe_cnt <= 0;
      end
    end
  end

  // Driver tasks
  task automatic add_tx(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t t;
    t = '0;
    t.idx = 1'(i); t.we = w; t.addr = a; t.data = d;
    pq[i].push_back(t);
  endtask

  task automatic drive_port(input int i);
    if (pq[i].size() == 0) req[i] = 1'b0;
    else begin
      req[i] = 1'b1;
      we[i]  = pq[i][0].we;
      if (i == 0) begin addr0 = pq[i][0].addr; wdata0 = pq[i][0].data; end
      else        begin addr1 = pq[i][0].addr; wdata1 = pq[i][0].data; end
    end
  endtask

  // Raise all queued requests at once; expected order, data and ack cycles come
  // from the round-robin rule and the register model, applied transaction by transaction.
  task automatic run(input bit drop1);
    exp_t q0[$], q1[$], e;
    int start, nxt, budget;
    bit pick, done;
    q0 = pq[0];
    q1 = pq[1];
    @(posedge clk); #1;
    drive_port(0);
    drive_port(1);
    start = cyc;
    nxt = start + LAT;
    while (q0.size() + q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) pick = !lg_model;
      else pick = (q1.size() > 0);
      lg_model = pick;
      if (pick) e = q1.pop_front(); else e = q0.pop_front();
      if (e.we) ref_mem[e.addr] = e.data;
      else e.data = ref_mem[e.addr];
      e.cyc = nxt;
      nxt += LAT + 1;
      exp_q.push_back(e);
    end
    budget = (pq[0].size() + pq[1].size() + 1) * (LAT + 2);
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (ack[i] && pq[i].size() > 0) begin
          pq[i].delete(0);
          drive_port(i);
        end
      if (drop1 && cyc - start == 12) req[1] = 1'b0;
      done = (pq[0].size() + pq[1].size() == 0);
    end
    check("run_complete", 32'(done), 32'd1);
    if (!done) begin
      pq[0].delete(); pq[1].delete(); exp_q.delete();
      req = 2'b00;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0, n1;
    bit found;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i]  = init_mem[i];
    end
    init_mem[8'h22] = 8'h37;
    ref_mem[8'h22]  = 8'h37;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_ad_n", 32'(ad_n), 32'd1);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_bus_oe", 32'(bus_oe), 32'd0);
    check("rst_bus_out", 32'(bus_out), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    add_tx(0, 1'b1, 8'h21, 8'h45);
    run(1'b0);
    add_tx(1, 1'b0, 8'h22, 8'h00);
    run(1'b0);
    for (int k = 0; k < 2; k++) begin
      add_tx(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      add_tx(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    run(1'b0);
    add_tx(1, 1'b0, 8'h21, 8'h00);
    run(1'b1);

    // Reset during the data strobe of a read
    @(posedge clk); #1;
    we[1] = 1'b0; addr1 = 8'h05; req[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 2 * LAT && !found; k++) begin
      @(negedge clk);
      found = !cs_n && ad_n;
    end
    check("reach_data_strobe", 32'(found), 32'd1);
    req = 2'b00;
    #3 reset = 1'b0;
    #1;
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_rd_n", 32'(rd_n), 32'd1);
    check("midrst_strobes", 32'({ad_n, wr_n}), 32'd3);
    check("midrst_bus_oe", 32'(bus_oe), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lg_model = 1'b1;
    last_rd = 8'd0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rdata", 32'(rdata), 32'd0);
    repeat (LAT + 5) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    repeat (8) begin
      n0 = $urandom_range(0, 2);
      n1 = (n0 == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int k = 0; k < n0; k++)
        add_tx(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      for (int k = 0; k < n1; k++)
        add_tx(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      run(1'b0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
